// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM-stage controller: data-memory bus handshake, lane steering, load extension
// Holds the upstream pipeline via stall while a bus transaction is outstanding; aborts hung transactions.
module mem_access_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  MemSize,
  input  logic        MemSigned,
  input  logic [31:0] ALUOut,
  input  logic [31:0] WriteData,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic [31:0] Memout,
  output logic        stall,
  output logic        misalign,
  output logic        bus_err
);

  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [1:0]      size_q, off_q;
  logic            signed_q;
  logic            op, misaligned_op, launch, timeout_hit;
  logic [3:0]      be_nxt;
  logic [31:0]     wdata_nxt, load_data;
  logic [7:0]      lane_byte;
  logic [15:0]     lane_half;

  always_comb begin
    op            = MemRead | MemWrite;
    misaligned_op = op && ((MemSize == 2'b01 && ALUOut[0]) ||
                           (MemSize[1] && ALUOut[1:0] != 2'b00));
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    stall       = 1'b0;
    misalign    = 1'b0;
    dmem_req    = 1'b0;
    launch      = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        misalign = misaligned_op;
        if (op && !misaligned_op) begin
          launch    = 1'b1;
          stall     = 1'b1;
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        dmem_req = 1'b1;
        stall    = 1'b1;
        if (dmem_ack) begin
          state_nxt = DONE;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          timeout_hit = 1'b1;
          state_nxt   = DONE;
        end
      end
      // EX/MEM still presents the finished op here, so inputs are ignored
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Little-endian lane steering for the launch cycle
  always_comb begin
    case (MemSize)
      2'b00: begin
        be_nxt    = 4'b0001 << ALUOut[1:0];
        wdata_nxt = {4{WriteData[7:0]}};
      end
      2'b01: begin
        be_nxt    = ALUOut[1] ? 4'b1100 : 4'b0011;
        wdata_nxt = {2{WriteData[15:0]}};
      end
      default: begin
        be_nxt    = 4'b1111;
        wdata_nxt = WriteData;
      end
    endcase
  end

  always_comb begin
    lane_byte = dmem_rdata[{off_q, 3'b000} +: 8];
    lane_half = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (size_q)
      2'b00:   load_data = {{24{signed_q & lane_byte[7]}}, lane_byte};
      2'b01:   load_data = {{16{signed_q & lane_half[15]}}, lane_half};
      default: load_data = dmem_rdata;
    endcase
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      cnt        <= '0;
      size_q     <= 2'b00;
      off_q      <= 2'b00;
      signed_q   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= 32'h0;
      dmem_be    <= 4'h0;
      dmem_wdata <= 32'h0;
      Memout     <= 32'h0;
      bus_err    <= 1'b0;
    end else begin
      if (launch) begin
        dmem_addr  <= {ALUOut[31:2], 2'b00};
        dmem_be    <= be_nxt;
        dmem_wdata <= wdata_nxt;
        dmem_we    <= MemWrite;
        size_q     <= MemSize;
        signed_q   <= MemSigned;
        off_q      <= ALUOut[1:0];
        cnt        <= '0;
      end else if (state == ACCESS && !dmem_ack && !timeout_hit) begin
        cnt <= cnt + 1'b1;
      end
      bus_err <= timeout_hit;
      if (state == ACCESS && dmem_ack && !dmem_we) Memout <= load_data;
      else if (timeout_hit)                         Memout <= 32'h0;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - self-checking bench for mem_access_stage
// Transaction-level model predicts per-cycle outputs; directed cases pin the model.
module tb_mem_access_stage;
  localparam int TIMEOUT = 16;

  logic        clock = 1'b0;
  logic        rst = 1'b0;
  logic        MemRead = 1'b0, MemWrite = 1'b0, MemSigned = 1'b0;
  logic [1:0]  MemSize = 2'b00;
  logic [31:0] ALUOut = 32'h0, WriteData = 32'h0;
  logic        dmem_req, dmem_we, dmem_ack = 1'b0;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata = 32'h0, Memout;
  logic [3:0]  dmem_be;
  logic        stall, misalign, bus_err;

  always #5 clock = ~clock;

  mem_access_stage #(.TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite),
    .MemSize(MemSize), .MemSigned(MemSigned), .ALUOut(ALUOut), .WriteData(WriteData),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .Memout(Memout), .stall(stall), .misalign(misalign), .bus_err(bus_err)
  );

  int   n_checks = 0, n_fail = 0;
  int   stall_cnt = 0, req_cnt = 0, berr_cnt = 0;
  bit   chk_en = 1'b0;
  logic exp_stall = 0, exp_req = 0, exp_mis = 0, exp_berr = 0, exp_we = 0;
  logic [31:0] exp_memout = 0, exp_addr = 0, exp_wdata = 0;
  logic [3:0]  exp_be = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic bit is_mis(input logic [1:0] sz, input logic [31:0] a);
    return (int'(a[1:0]) % nbytes(sz)) != 0;
  endfunction

  function automatic logic [3:0] be_of(input logic [1:0] sz, input logic [31:0] a);
    int n = nbytes(sz);
    return 4'(((1 << n) - 1) << int'(a[1:0]));
  endfunction

  function automatic logic [31:0] wdata_of(input logic [1:0] sz, input logic [31:0] wd);
    if (nbytes(sz) == 1) return (wd & 32'hFF) * 32'h01010101;
    if (nbytes(sz) == 2) return (wd & 32'hFFFF) * 32'h00010001;
    return wd;
  endfunction

  function automatic logic [31:0] load_of(input logic [1:0] sz, input logic sg,
                                          input logic [31:0] a, input logic [31:0] rd);
    int n = nbytes(sz);
    logic [31:0] v, mask;
    if (n == 4) return rd;
    mask = (32'h1 << (8 * n)) - 1;
    v = (rd >> (8 * int'(a[1:0]))) & mask;
    if (sg && v >= (32'h1 << (8 * n - 1))) v = v | ~mask;
    return v;
  endfunction

  task automatic compare_loop();
    forever begin
      @(negedge clock);
      if (rst) begin
        stall_cnt += int'(stall);
        req_cnt   += int'(dmem_req);
        berr_cnt  += int'(bus_err);
      end
      if (chk_en) begin
        chk("stall", stall, exp_stall);
        chk("dmem_req", dmem_req, exp_req);
        chk("misalign", misalign, exp_mis);
        chk("bus_err", bus_err, exp_berr);
        chk("Memout", Memout, exp_memout);
        if (exp_req) begin
          chk("dmem_addr", dmem_addr, exp_addr);
          chk("dmem_be", dmem_be, exp_be);
          chk("dmem_we", dmem_we, exp_we);
          chk("dmem_wdata", dmem_wdata, exp_wdata);
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // One EX/MEM op; returns inside its last cycle (DONE, or the single IDLE cycle)
  task automatic run_op(input logic rd, input logic wr, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdv,
                        input int delay);
    int k;
    bit opv, mis;
    step();
    MemRead = rd; MemWrite = wr; MemSize = sz; MemSigned = sg; ALUOut = a; WriteData = wd;
    dmem_ack = 1'($urandom); dmem_rdata = $urandom;
    opv = rd | wr;
    mis = opv && is_mis(sz, a);
    exp_req = 0; exp_berr = 0; exp_mis = mis; exp_stall = opv && !mis;
    if (!exp_stall) return;
    exp_addr = a & ~32'h3; exp_be = be_of(sz, a); exp_we = wr; exp_wdata = wdata_of(sz, wd);
    k = 0;
    forever begin
      step();
      exp_req = 1; exp_stall = 1; exp_mis = 0;
      dmem_ack = (k == delay);
      dmem_rdata = (k == delay) ? rdv : $urandom;
      if (k == delay || k == TIMEOUT - 1) break;
      k++;
    end
    step();
    dmem_ack = 1'($urandom); dmem_rdata = $urandom;
    exp_req = 0; exp_stall = 0; exp_mis = 0;
    if (k == delay) begin
      if (!wr) exp_memout = load_of(sz, sg, a, rdv);
    end else begin
      exp_memout = 32'h0;
      exp_berr = 1;
    end
  endtask

  task automatic settle();
    @(negedge clock);
    #1;
  endtask

  logic        r_rd, r_wr, r_sg;
  logic [1:0]  r_sz;
  logic [31:0] r_a;
  int          r_kind, r_d;

  initial begin
    fork compare_loop(); join_none

    step(); step();
    settle();
    chk("rst dmem_req", dmem_req, 0);
    chk("rst dmem_we", dmem_we, 0);
    chk("rst dmem_addr", dmem_addr, 0);
    chk("rst dmem_be", dmem_be, 0);
    chk("rst dmem_wdata", dmem_wdata, 0);
    chk("rst Memout", Memout, 0);
    chk("rst bus_err", bus_err, 0);
    chk("rst stall", stall, 0);

    step();
    rst = 1'b1;
    chk_en = 1'b1;

    stall_cnt = 0;
    run_op(1, 0, 2'b00, 1, 32'h103, 32'h0, 32'h80FF1234, 0);
    settle();
    chk("lb model", exp_memout, 32'hFFFFFF80);
    chk("lb be model", be_of(2'b00, 32'h103), 4'b1000);
    chk("lb Memout", Memout, 32'hFFFFFF80);
    chk("lb stall cycles", stall_cnt, 2);

    run_op(1, 0, 2'b00, 0, 32'h103, 32'h0, 32'h80FF1234, 0);
    settle();
    chk("lbu Memout", Memout, 32'h00000080);

    run_op(0, 1, 2'b01, 0, 32'h102, 32'h0000ABCD, $urandom, 0);
    settle();
    chk("sh wdata model", wdata_of(2'b01, 32'h0000ABCD), 32'hABCDABCD);
    chk("sh be model", be_of(2'b01, 32'h102), 4'b1100);
    chk("sh Memout kept", Memout, 32'h00000080);

    stall_cnt = 0;
    run_op(1, 0, 2'b10, 0, 32'h200, 32'h0, 32'h12345678, 3);
    settle();
    chk("lw wait stall cycles", stall_cnt, 5);
    chk("lw wait Memout", Memout, 32'h12345678);
    stall_cnt = 0;
    run_op(1, 0, 2'b10, 0, 32'h204, 32'h0, 32'hCAFEF00D, 0);
    settle();
    chk("b2b stall cycles", stall_cnt, 2);
    chk("b2b Memout", Memout, 32'hCAFEF00D);

    stall_cnt = 0; req_cnt = 0;
    run_op(1, 0, 2'b10, 0, 32'h101, 32'h0, 32'h0, 0);
    settle();
    chk("lw mis misalign", misalign, 1);
    run_op(1, 0, 2'b01, 0, 32'h103, 32'h0, 32'h0, 0);
    settle();
    chk("lh mis misalign", misalign, 1);
    chk("mis stall cycles", stall_cnt, 0);
    chk("mis req cycles", req_cnt, 0);

    req_cnt = 0; berr_cnt = 0;
    run_op(1, 0, 2'b10, 0, 32'h300, 32'h0, 32'h0, -1);
    settle();
    chk("timeout req cycles", req_cnt, TIMEOUT);
    chk("timeout bus_err", bus_err, 1);
    chk("timeout Memout", Memout, 0);
    run_op(0, 0, 2'b00, 0, 32'h0, 32'h0, 32'h0, 0);
    settle();
    chk("timeout bus_err pulse", berr_cnt, 1);

    for (int i = 0; i < 80; i++) begin
      r_kind = $urandom_range(0, 9);
      r_rd = (r_kind >= 1 && r_kind <= 5) || r_kind == 9;
      r_wr = (r_kind >= 6);
      r_sz = 2'($urandom_range(0, 3));
      r_sg = 1'($urandom);
      r_a  = $urandom;
      r_d  = ($urandom_range(0, 9) == 0) ? -1 : $urandom_range(0, 5);
      run_op(r_rd, r_wr, r_sz, r_sg, r_a, $urandom, $urandom, r_d);
    end

    run_op(1, 0, 2'b10, 0, 32'h400, 32'h0, 32'h11111111, 0);
    chk_en = 1'b0;
    step();
    MemRead = 1; MemWrite = 0; MemSize = 2'b10; ALUOut = 32'h500; dmem_ack = 0;
    step();
    step();
    rst = 1'b0;
    #1;
    chk("reset mid-access dmem_req", dmem_req, 0);
    chk("reset mid-access Memout", Memout, 0);
    step();
    MemRead = 0;
    rst = 1'b1;
    berr_cnt = 0;
    dmem_ack = 1; dmem_rdata = 32'hDEADBEEF;
    step();
    step();
    settle();
    chk("late ack Memout", Memout, 0);
    chk("late ack dmem_req", dmem_req, 0);
    chk("late ack stall", stall, 0);
    chk("late ack no DONE", berr_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
